// File: rtl/cache_nway_wb_if.sv
// CPU request/ack and AXI-bridge rd/wr signal bundle for cache_nway_wb.
// Latency: none (wires only).
// Backpressure: addr_ok stalls the CPU; rd_rdy and wr_rdy stall the cache.
// Ports: slave = cache view, master = CPU + bridge view.
interface cache_nway_wb_if #(
    parameter int LINE_WORDS = 4
);
    // CPU side
    logic                      valid;
    logic                      op;
    logic                      uncached;
    logic [31:0]               addr;
    logic [3:0]                wstrb;
    logic [31:0]               wdata;
    logic                      addr_ok;
    logic                      data_ok;
    logic [31:0]               rdata;
    // Bridge read channel
    logic                      rd_req;
    logic [2:0]                rd_type;
    logic [31:0]               rd_addr;
    logic                      rd_rdy;
    logic                      ret_valid;
    logic                      ret_last;
    logic [31:0]               ret_data;
    // Bridge write channel
    logic                      wr_req;
    logic [2:0]                wr_type;
    logic [31:0]               wr_addr;
    logic [3:0]                wr_wstrb;
    logic [32*LINE_WORDS-1:0]  wr_data;
    logic                      wr_rdy;

    modport slave (
        input  valid, op, uncached, addr, wstrb, wdata,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        output addr_ok, data_ok, rdata,
        output rd_req, rd_type, rd_addr,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data
    );

    modport master (
        output valid, op, uncached, addr, wstrb, wdata,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        input  addr_ok, data_ok, rdata,
        input  rd_req, rd_type, rd_addr,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data
    );
endinterface

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back/write-allocate blocking L1 cache with uncached bypass.
// Latency: hit acks in LOOKUP (1 cycle after accept); read miss acks on the critical refill beat.
// Backpressure: one outstanding request (addr_ok only in IDLE); wr_req/rd_req held until wr_rdy/rd_rdy.
// Ports: clk_i, reset_i (sync, active-high); bus_io carries the CPU and bridge signals.
module cache_nway_wb #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    cache_nway_wb_if.slave bus_io
);
    localparam int WO_W  = $clog2(LINE_WORDS);
    localparam int OFF_W = WO_W + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MISS    = 3'd2;
    localparam logic [2:0] S_REPLACE = 3'd3;
    localparam logic [2:0] S_REFILL  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic                    req_op_q, req_unc_q;
    logic [31:0]             req_addr_q, req_wdata_q;
    logic [3:0]              req_wstrb_q;
    logic [WAY_W-1:0]        victim_q, victim_d;
    logic [WO_W-1:0]         cnt_q;

    logic [TAG_W-1:0]        tag_q   [WAYS][SETS];
    logic [31:0]             data_q  [WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0]         valid_q [WAYS];
    logic [SETS-1:0]         dirty_q [WAYS];
    logic [WAY_W-1:0]        rr_q    [SETS];

    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        req_tag;
    logic [WO_W-1:0]         woff;
    logic                    hit, inv_found;
    logic [WAY_W-1:0]        hit_way, inv_way;
    logic                    data_ok_c;
    logic [31:0]             rdata_c;
    logic                    rd_req_c, wr_req_c;
    logic [32*LINE_WORDS-1:0] victim_line;

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign idx     = req_addr_q[OFF_W +: IDX_W];
    assign req_tag = req_addr_q[31 -: TAG_W];
    assign woff    = req_addr_q[2 +: WO_W];

    // Tag probe plus victim choice: first invalid way wins over the round-robin pointer.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][idx] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_d = inv_found ? inv_way : rr_q[idx];
    end

    always_comb begin
        victim_line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            victim_line[32*i +: 32] = data_q[victim_q][idx][i];
        end
    end

    always_comb begin
        state_d   = state_q;
        data_ok_c = 1'b0;
        rdata_c   = 32'h0;
        rd_req_c  = 1'b0;
        wr_req_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_io.valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (req_unc_q) begin
                    // Uncached stores are acked before the bridge write goes out.
                    data_ok_c = req_op_q;
                    state_d   = req_op_q ? S_MISS : S_REPLACE;
                end else if (hit) begin
                    data_ok_c = 1'b1;
                    if (!req_op_q) rdata_c = data_q[hit_way][idx][woff];
                    state_d   = S_IDLE;
                end else begin
                    // Write miss is acked now; the store waits in the request buffer for the refill.
                    data_ok_c = req_op_q;
                    state_d   = (valid_q[victim_d][idx] && dirty_q[victim_d][idx]) ? S_MISS : S_REPLACE;
                end
            end
            S_MISS: begin
                wr_req_c = 1'b1;
                if (bus_io.wr_rdy) state_d = req_unc_q ? S_IDLE : S_REPLACE;
            end
            S_REPLACE: begin
                rd_req_c = 1'b1;
                if (bus_io.rd_rdy) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (bus_io.ret_valid) begin
                    if (req_unc_q ? bus_io.ret_last : (!req_op_q && cnt_q == woff)) begin
                        data_ok_c = 1'b1;
                        rdata_c   = bus_io.ret_data;
                    end
                    if (bus_io.ret_last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: the only storage cleared by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_LOOKUP && !req_unc_q && hit && req_op_q) dirty_q[hit_way][idx] <= 1'b1;
            if (state_q == S_REFILL && !req_unc_q && bus_io.ret_valid) begin
                cnt_q <= cnt_q + 1'b1;
                if (bus_io.ret_last) begin
                    cnt_q                   <= '0;
                    valid_q[victim_q][idx]  <= 1'b1;
                    dirty_q[victim_q][idx]  <= req_op_q;
                    rr_q[idx]               <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
                end
            end
        end
    end

    // Request buffer, victim latch, tag and data arrays: contents are don't-care until marked valid.
    always_ff @(posedge clk_i) begin
        if (bus_io.valid && state_q == S_IDLE) begin
            req_op_q    <= bus_io.op;
            req_unc_q   <= bus_io.uncached;
            req_addr_q  <= bus_io.addr;
            req_wstrb_q <= bus_io.wstrb;
            req_wdata_q <= bus_io.wdata;
        end
        if (state_q == S_LOOKUP) victim_q <= victim_d;
        if (!reset_i) begin
            if (state_q == S_LOOKUP && !req_unc_q && hit && req_op_q) begin
                data_q[hit_way][idx][woff] <= merge_be(data_q[hit_way][idx][woff], req_wdata_q, req_wstrb_q);
            end
            if (state_q == S_REFILL && !req_unc_q && bus_io.ret_valid) begin
                data_q[victim_q][idx][cnt_q] <= (req_op_q && cnt_q == woff)
                    ? merge_be(bus_io.ret_data, req_wdata_q, req_wstrb_q) : bus_io.ret_data;
                if (bus_io.ret_last) tag_q[victim_q][idx] <= req_tag;
            end
        end
    end

    assign bus_io.addr_ok  = reset_i | (state_q == S_IDLE);
    assign bus_io.data_ok  = data_ok_c & ~reset_i;
    assign bus_io.rdata    = reset_i ? 32'h0 : rdata_c;
    assign bus_io.rd_req   = rd_req_c & ~reset_i;
    assign bus_io.wr_req   = wr_req_c & ~reset_i;
    assign bus_io.rd_type  = req_unc_q ? 3'd2 : 3'd4;
    assign bus_io.rd_addr  = req_unc_q ? req_addr_q : {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign bus_io.wr_type  = req_unc_q ? 3'd2 : 3'd4;
    assign bus_io.wr_addr  = req_unc_q ? req_addr_q : {tag_q[victim_q][idx], idx, {OFF_W{1'b0}}};
    assign bus_io.wr_wstrb = req_unc_q ? req_wstrb_q : 4'hF;
    assign bus_io.wr_data  = req_unc_q ? {{(32*LINE_WORDS-32){1'b0}}, req_wdata_q} : victim_line;
endmodule
